// File: rtl/layer_scan_ctl.sv
// Read-side frame scheduler: fetches 64 pixels per frame from the idle bank and starts the 8 layer
// serializers once per pixel (1-cycle RAM latency); waits on tx_done_in with no timeout, then times the latch gap.
module layer_scan_ctl #(
   parameter int RST_CYCLES = 14000,
   parameter int CNT_W      = 16
) (
   input  logic       clk_in,
   input  logic       rst_n_in,
   input  logic       frame_rdy_in,
   input  logic       tx_done_in,
   output logic       rd_en_out,
   output logic [5:0] rd_addr_out,
   output logic       bank_sel_out,
   output logic       tx_start_out,
   output logic       busy_out,
   output logic       frame_done_out
);

   typedef enum logic [2:0] {IDLE, READ, LOAD, SEND, GAP} state_t;

   localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(RST_CYCLES - 1);

   state_t           state;
   logic             pending;
   logic [CNT_W-1:0] gap_cnt;
   logic             consume;

   assign consume = (state == IDLE) && pending;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state          <= IDLE;
         pending        <= 1'b0;
         gap_cnt        <= '0;
         rd_en_out      <= 1'b0;
         rd_addr_out    <= '0;
         bank_sel_out   <= 1'b0;
         tx_start_out   <= 1'b0;
         busy_out       <= 1'b0;
         frame_done_out <= 1'b0;
      end else begin
         // A frame arriving on the consumption cycle must survive as the next frame.
         pending        <= frame_rdy_in | (pending & ~consume);
         rd_en_out      <= 1'b0;
         tx_start_out   <= 1'b0;
         frame_done_out <= 1'b0;
         case (state)
            IDLE: begin
               if (pending) begin
                  bank_sel_out <= ~bank_sel_out;
                  rd_addr_out  <= '0;
                  rd_en_out    <= 1'b1;
                  busy_out     <= 1'b1;
                  state        <= READ;
               end
            end
            READ: begin
               tx_start_out <= 1'b1;
               state        <= LOAD;
            end
            LOAD: begin
               state <= SEND;
            end
            SEND: begin
               if (tx_done_in) begin
                  if (rd_addr_out == 6'd63) begin
                     gap_cnt <= GAP_LOAD;
                     state   <= GAP;
                  end else begin
                     rd_addr_out <= rd_addr_out + 6'd1;
                     rd_en_out   <= 1'b1;
                     state       <= READ;
                  end
               end
            end
            GAP: begin
               if (gap_cnt == '0) begin
                  frame_done_out <= 1'b1;
                  busy_out       <= 1'b0;
                  state          <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt - CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_layer_scan_ctl.sv
// Bench for layer_scan_ctl: frame-level reference model compared every cycle, plus directed timing checks.
module tb_layer_scan_ctl;

   localparam int RST = 4;
   localparam int RESP_DLY = 30;

   logic       clk_in = 1'b0;
   logic       rst_n_in = 1'b0;
   logic       frame_rdy_in = 1'b0;
   logic       tx_done_in = 1'b0;
   logic       rd_en_out;
   logic [5:0] rd_addr_out;
   logic       bank_sel_out;
   logic       tx_start_out;
   logic       busy_out;
   logic       frame_done_out;

   layer_scan_ctl #(.RST_CYCLES(RST), .CNT_W(16)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .frame_rdy_in(frame_rdy_in), .tx_done_in(tx_done_in),
      .rd_en_out(rd_en_out), .rd_addr_out(rd_addr_out), .bank_sel_out(bank_sel_out),
      .tx_start_out(tx_start_out), .busy_out(busy_out), .frame_done_out(frame_done_out)
   );

   always #5 clk_in = ~clk_in;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Frame-level model: pix = pixel in flight (-1 none), age = cycles since its fetch,
   // gap = latch cycles still to run.
   typedef struct {
      int pix;
      int age;
      int gap;
      int addr;
      bit pend;
      bit bank;
      bit done;
   } model_t;

   function automatic model_t model_reset();
      model_t r;
      r.pix = -1; r.age = 0; r.gap = 0; r.addr = 0;
      r.pend = 1'b0; r.bank = 1'b0; r.done = 1'b0;
      return r;
   endfunction

   function automatic model_t step(input model_t m, input logic frdy, input logic tdone);
      model_t n = m;
      n.done = 1'b0;
      n.pend = m.pend | frdy;
      if (m.gap > 0) begin
         n.gap  = m.gap - 1;
         n.done = (n.gap == 0);
      end else if (m.pix >= 0) begin
         if (m.age < 2) begin
            n.age = m.age + 1;
         end else if (tdone) begin
            if (m.pix == 63) begin
               n.pix = -1;
               n.gap = RST;
            end else begin
               n.pix  = m.pix + 1;
               n.addr = m.pix + 1;
               n.age  = 0;
            end
         end
      end else if (m.pend) begin
         n.bank = ~m.bank;
         n.pix  = 0;
         n.addr = 0;
         n.age  = 0;
         n.pend = frdy;
      end
      return n;
   endfunction

   model_t m;

   always @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) m <= model_reset();
      else           m <= step(m, frame_rdy_in, tx_done_in);
   end

   always @(negedge clk_in) begin
      chk("rd_en",      int'(rd_en_out),      int'(m.pix >= 0 && m.age == 0));
      chk("tx_start",   int'(tx_start_out),   int'(m.pix >= 0 && m.age == 1));
      chk("busy",       int'(busy_out),       int'(m.pix >= 0 || m.gap > 0));
      chk("rd_addr",    int'(rd_addr_out),    m.addr);
      chk("bank_sel",   int'(bank_sel_out),   int'(m.bank));
      chk("frame_done", int'(frame_done_out), int'(m.done));
   end

   // Observation and serializer responder, advanced one clock per tick.
   int cyc = 0;
   int resp_cnt = 0;
   int n_resp, resp_td_cyc;
   int n_start, n_rden, first_start, first_rden, first_rden_addr, first_bank_cyc, bank_chg;
   int done_busy;
   logic prev_bank = 1'b0;
   int addr_q[$];
   int done_q[$];
   int start_q[$];

   task automatic clear_stats();
      n_resp = 0; resp_td_cyc = -1;
      n_start = 0; n_rden = 0; first_start = -1; first_rden = -1; first_rden_addr = -1;
      first_bank_cyc = -1; bank_chg = 0; done_busy = -1;
      addr_q.delete(); done_q.delete(); start_q.delete();
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
      cyc++;
      frame_rdy_in = 1'b0;
      tx_done_in   = 1'b0;
      if (tx_start_out) begin
         n_start++;
         addr_q.push_back(int'(rd_addr_out));
         if (first_start < 0) first_start = cyc;
         resp_cnt = RESP_DLY;
      end else if (resp_cnt > 0) begin
         resp_cnt--;
         if (resp_cnt == 0) begin
            tx_done_in  = 1'b1;
            n_resp++;
            resp_td_cyc = cyc;
         end
      end
      if (rd_en_out) begin
         n_rden++;
         if (first_rden < 0) begin
            first_rden      = cyc;
            first_rden_addr = int'(rd_addr_out);
         end
         if (rd_addr_out == 6'd0) start_q.push_back(cyc);
      end
      if (bank_sel_out != prev_bank) begin
         bank_chg++;
         if (first_bank_cyc < 0) first_bank_cyc = cyc;
         prev_bank = bank_sel_out;
      end
      if (frame_done_out) begin
         done_q.push_back(cyc);
         done_busy = int'(busy_out);
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_done(input int n);
      int budget = 6000;
      while (done_q.size() < n && budget > 0) begin
         tick();
         budget--;
      end
      chk("wait_frame_done", done_q.size(), n);
   endtask

   task automatic wait_starts(input int n);
      int budget = 3000;
      while (n_start < n && budget > 0) begin
         tick();
         budget--;
      end
      chk("wait_tx_start", n_start, n);
   endtask

   task automatic chk_addr_order(input string name);
      int bad = 0;
      foreach (addr_q[i]) if (addr_q[i] != i) bad++;
      chk(name, bad, 0);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_rd_en"},      int'(rd_en_out),      0);
      chk({tag, "_rd_addr"},    int'(rd_addr_out),    0);
      chk({tag, "_bank_sel"},   int'(bank_sel_out),   0);
      chk({tag, "_tx_start"},   int'(tx_start_out),   0);
      chk({tag, "_busy"},       int'(busy_out),       0);
      chk({tag, "_frame_done"}, int'(frame_done_out), 0);
   endtask

   int k;
   int diff;

   initial begin
      clear_stats();
      ticks(3);
      chk_outputs_zero("reset");
      rst_n_in = 1'b1;
      ticks(2);

      // Single frame: bank toggles and pixel 0 is fetched two cycles after the pulse.
      clear_stats();
      k = cyc;
      frame_rdy_in = 1'b1;
      tick();
      wait_done(1);
      chk("t1_bank_cycle", first_bank_cyc, k + 2);
      chk("t1_first_rden_cycle", first_rden, k + 2);
      chk("t1_first_rden_addr", first_rden_addr, 0);
      chk("t1_start_after_rden", first_start - first_rden, 1);
      chk("t1_tx_start_count", n_start, 64);
      chk_addr_order("t1_addr_order");
      // tx_done is sampled one edge after its cycle; the gap then spans RST edges.
      chk("t1_done_delay", (done_q.size() > 0) ? done_q[0] - resp_td_cyc : -1, RST + 1);
      chk("t1_busy_at_done", done_busy, 0);
      chk("t1_bank_now", int'(bank_sel_out), 1);
      ticks(5);
      chk("t1_idle_busy", int'(busy_out), 0);

      // Three requests during pixel 10 collapse into one extra frame.
      clear_stats();
      frame_rdy_in = 1'b1;
      tick();
      wait_starts(11);
      tick();
      frame_rdy_in = 1'b1;
      tick();
      tick();
      frame_rdy_in = 1'b1;
      tick();
      frame_rdy_in = 1'b1;
      tick();
      wait_done(2);
      ticks(100);
      chk("t2_frames", done_q.size(), 2);
      chk("t2_bank_toggles", bank_chg, 2);
      chk("t2_tx_starts", n_start, 128);
      chk("t2_busy_idle", int'(busy_out), 0);
      chk("t2_bank_now", int'(bank_sel_out), 1);

      // Request coinciding with consumption chains the next frame right after frame_done.
      clear_stats();
      frame_rdy_in = 1'b1;
      tick();
      frame_rdy_in = 1'b1;
      tick();
      wait_done(2);
      ticks(10);
      diff = (start_q.size() >= 2 && done_q.size() >= 1) ? start_q[1] - done_q[0] : -1;
      chk("t3_back_to_back", diff, 1);
      chk("t3_frames", done_q.size(), 2);
      chk("t3_bank_toggles", bank_chg, 2);

      // Spurious tx_done in IDLE, READ, LOAD and GAP.
      clear_stats();
      k = cyc;
      frame_rdy_in = 1'b1;
      tx_done_in   = 1'b1;
      tick();
      tx_done_in = 1'b1;
      tick();
      tx_done_in = 1'b1;
      tick();
      tx_done_in = 1'b1;
      tick();
      begin
         int budget = 6000;
         while (done_q.size() < 1 && budget > 0) begin
            tick();
            if (n_resp == 64 && busy_out) tx_done_in = 1'b1;
            budget--;
         end
      end
      chk("t4_frames", done_q.size(), 1);
      chk("t4_first_rden_cycle", first_rden, k + 2);
      chk("t4_tx_start_count", n_start, 64);
      chk_addr_order("t4_addr_order");
      chk("t4_gap_len", (done_q.size() > 0) ? done_q[0] - resp_td_cyc : -1, RST + 1);
      tx_done_in = 1'b1;
      tick();
      ticks(5);
      chk("t4_idle_busy", int'(busy_out), 0);
      chk("t4_idle_addr_hold", int'(rd_addr_out), 63);
      chk("t4_bank_now", int'(bank_sel_out), 0);

      // Asynchronous reset while sending pixel 37.
      clear_stats();
      frame_rdy_in = 1'b1;
      tick();
      wait_starts(38);
      ticks(5);
      chk("t5_addr_before_reset", int'(rd_addr_out), 37);
      chk("t5_busy_before_reset", int'(busy_out), 1);
      #3;
      rst_n_in = 1'b0;
      #1;
      chk_outputs_zero("t5_async");
      resp_cnt = 0;
      ticks(2);
      rst_n_in = 1'b1;
      clear_stats();
      prev_bank = bank_sel_out;
      ticks(50);
      chk("t5_no_restart", n_rden, 0);
      chk("t5_idle_busy", int'(busy_out), 0);
      k = cyc;
      frame_rdy_in = 1'b1;
      tick();
      wait_done(1);
      chk("t5_first_rden_cycle", first_rden, k + 2);
      chk("t5_first_rden_addr", first_rden_addr, 0);
      chk("t5_bank_cycle", first_bank_cyc, k + 2);
      chk("t5_bank_now", int'(bank_sel_out), 1);
      chk("t5_tx_start_count", n_start, 64);
      ticks(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
